// File: rtl/q8_8_add_sub_if.sv
// Operand/result bundle for the Q8.8 add/sub unit; master drives operands, slave returns results.
interface q8_8_add_sub_if;
    logic        in_valid;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        add_sub;
    logic        out_valid;
    logic [16:0] result;
    logic [15:0] result_sat;
    logic        overflow;

    modport master (
        output in_valid, operand1, operand2, add_sub,
        input  out_valid, result, result_sat, overflow
    );

    modport slave (
        input  in_valid, operand1, operand2, add_sub,
        output out_valid, result, result_sat, overflow
    );
endinterface

// File: rtl/q8_8_add_sub.sv
// Registered Q8.8 add/sub giving a full Q9.8 result plus a clamped Q8.8 result and overflow flag.
// One cycle latency, one operation accepted per cycle, no backpressure.
module q8_8_add_sub #(
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    q8_8_add_sub_if.slave    bus
);

    logic        ext_a;
    logic        ext_b;
    logic [16:0] a_ext;
    logic [16:0] b_ext;
    logic [16:0] b_op;
    logic [16:0] sum;
    logic        clamp;
    logic [15:0] sat_val;

    logic        out_valid_q, out_valid_d;
    logic [16:0] result_q,    result_d;
    logic [15:0] result_sat_q, result_sat_d;
    logic        overflow_q,  overflow_d;

    assign ext_a = SIGNED ? bus.operand1[15] : 1'b0;
    assign ext_b = SIGNED ? bus.operand2[15] : 1'b0;
    assign a_ext = {ext_a, bus.operand1};
    assign b_ext = {ext_b, bus.operand2};

    // Subtract is A + ~B + 1; the 17-bit width keeps both the signed and unsigned cases exact.
    assign b_op = bus.add_sub ? ~b_ext : b_ext;
    assign sum  = a_ext + b_op + {16'd0, bus.add_sub};

    always_comb begin
        clamp   = 1'b0;
        sat_val = sum[15:0];
        if (SIGNED) begin
            if (sum[16] != sum[15]) begin
                clamp   = 1'b1;
                sat_val = sum[16] ? 16'h8000 : 16'h7FFF;
            end
        end else begin
            // Unsigned: bit 16 is the carry on add and the borrow on subtract.
            if (sum[16]) begin
                clamp   = 1'b1;
                sat_val = bus.add_sub ? 16'h0000 : 16'hFFFF;
            end
        end
    end

    always_comb begin
        out_valid_d  = bus.in_valid;
        result_d     = result_q;
        result_sat_d = result_sat_q;
        overflow_d   = overflow_q;
        if (bus.in_valid) begin
            result_d     = sum;
            result_sat_d = sat_val;
            overflow_d   = clamp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            result_q     <= 17'd0;
            result_sat_q <= 16'd0;
            overflow_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            result_sat_q <= result_sat_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.result     = result_q;
    assign bus.result_sat = result_sat_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_q8_8_add_sub.sv
// Directed-vector bench driving an unsigned and a signed instance of the Q8.8 add/sub unit.
module tb_q8_8_add_sub;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    q8_8_add_sub_if u_if0();
    q8_8_add_sub_if u_if1();

    q8_8_add_sub #(.SIGNED(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(u_if0));
    q8_8_add_sub #(.SIGNED(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_out0(input string tag, input logic vld, input logic [16:0] r,
                              input logic [15:0] s, input logic o);
        check({tag, ".vld"}, {31'd0, u_if0.out_valid}, {31'd0, vld});
        check({tag, ".res"}, {15'd0, u_if0.result}, {15'd0, r});
        check({tag, ".sat"}, {16'd0, u_if0.result_sat}, {16'd0, s});
        check({tag, ".ovf"}, {31'd0, u_if0.overflow}, {31'd0, o});
    endtask

    task automatic check_out1(input string tag, input logic vld, input logic [16:0] r,
                              input logic [15:0] s, input logic o);
        check({tag, ".vld"}, {31'd0, u_if1.out_valid}, {31'd0, vld});
        check({tag, ".res"}, {15'd0, u_if1.result}, {15'd0, r});
        check({tag, ".sat"}, {16'd0, u_if1.result_sat}, {16'd0, s});
        check({tag, ".ovf"}, {31'd0, u_if1.overflow}, {31'd0, o});
    endtask

    task automatic run0(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [16:0] er, input logic [15:0] es,
                        input logic eo);
        u_if0.in_valid = 1'b1;
        u_if0.operand1 = a;
        u_if0.operand2 = b;
        u_if0.add_sub  = s;
        @(posedge clk);
        #1;
        check_out0(tag, 1'b1, er, es, eo);
    endtask

    task automatic run1(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [16:0] er, input logic [15:0] es,
                        input logic eo);
        u_if1.in_valid = 1'b1;
        u_if1.operand1 = a;
        u_if1.operand2 = b;
        u_if1.add_sub  = s;
        @(posedge clk);
        #1;
        check_out1(tag, 1'b1, er, es, eo);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        u_if0.in_valid = 1'b0; u_if0.operand1 = 16'h0; u_if0.operand2 = 16'h0; u_if0.add_sub = 1'b0;
        u_if1.in_valid = 1'b0; u_if1.operand1 = 16'h0; u_if1.operand2 = 16'h0; u_if1.add_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_out0("rst0", 1'b0, 17'h0, 16'h0, 1'b0);
        check_out1("rst1", 1'b0, 17'h0, 16'h0, 1'b0);
        rst = 1'b0;

        // Unsigned instance
        run0("u_add",     16'h0108, 16'h0380, 1'b0, 17'h00488, 16'h0488, 1'b0);
        run0("u_sub",     16'h0402, 16'h0008, 1'b1, 17'h003FA, 16'h03FA, 1'b0);
        run0("u_borrow",  16'h0008, 16'h0402, 1'b1, 17'h1FC06, 16'h0000, 1'b1);
        run0("u_carry",   16'hFFFF, 16'h0001, 1'b0, 17'h10000, 16'hFFFF, 1'b1);
        run0("u_eq_sub",  16'h1234, 16'h1234, 1'b1, 17'h00000, 16'h0000, 1'b0);
        run0("u_maxadd",  16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 16'hFFFF, 1'b1);
        u_if0.in_valid = 1'b0;

        // Signed instance
        run1("s_pos_ovf", 16'h7F00, 16'h0100, 1'b0, 17'h08000, 16'h7FFF, 1'b1);
        run1("s_neg_ovf", 16'h8000, 16'h0100, 1'b1, 17'h17F00, 16'h8000, 1'b1);
        run1("s_add",     16'hFF00, 16'h0080, 1'b0, 17'h1FF80, 16'hFF80, 1'b0);
        run1("s_min_add", 16'h8000, 16'h8000, 1'b0, 17'h10000, 16'h8000, 1'b1);
        run1("s_sub_neg", 16'h0100, 16'h8000, 1'b1, 17'h08100, 16'h7FFF, 1'b1);
        run1("s_edge",    16'h7FFF, 16'h0000, 1'b0, 17'h07FFF, 16'h7FFF, 1'b0);
        u_if1.in_valid = 1'b0;

        // Back-to-back on the unsigned instance, then a gap
        run0("b2b0", 16'h0001, 16'h0002, 1'b0, 17'h00003, 16'h0003, 1'b0);
        run0("b2b1", 16'h1234, 16'h0034, 1'b1, 17'h01200, 16'h1200, 1'b0);
        run0("b2b2", 16'h8000, 16'h8000, 1'b0, 17'h10000, 16'hFFFF, 1'b1);
        u_if0.in_valid = 1'b0;
        u_if0.operand1 = 16'h0001;
        u_if0.operand2 = 16'h0001;
        @(posedge clk);
        #1;
        check_out0("gap", 1'b0, 17'h10000, 16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        check_out0("gap2", 1'b0, 17'h10000, 16'hFFFF, 1'b1);

        // Reset takes priority over a valid operation
        u_if0.in_valid = 1'b1; u_if0.operand1 = 16'hFFFF; u_if0.operand2 = 16'h0001; u_if0.add_sub = 1'b0;
        u_if1.in_valid = 1'b1; u_if1.operand1 = 16'h7F00; u_if1.operand2 = 16'h0100; u_if1.add_sub = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_out0("rst_vld0", 1'b0, 17'h0, 16'h0, 1'b0);
        check_out1("rst_vld1", 1'b0, 17'h0, 16'h0, 1'b0);
        rst = 1'b0;
        u_if0.in_valid = 1'b0;
        u_if1.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_out0("post_rst0", 1'b0, 17'h0, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
